// File: rtl/ibex_obi_resp_pkg.sv
// Shared types and helpers for the OBI memory responder: response record, error causes and the
// inverted SECDED(39,32) check-bit encoder used for bus integrity.
package ibex_obi_resp_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [6:0]  intg;
  } resp_t;

  typedef enum logic [1:0] {
    ErrNone,
    ErrRange,
    ErrAlign,
    ErrIntg
  } err_cause_e;

  // Check bits of the inverted Hsiao SECDED(39,32) code, matching the core's bus integrity.
  function automatic logic [6:0] secded_inv_39_32_intg(logic [31:0] data);
    logic [6:0] chk;
    chk[0] = ^(data & 32'h2606_BD25);
    chk[1] = ^(data & 32'hDEBA_8050);
    chk[2] = ^(data & 32'h413D_89AA);
    chk[3] = ^(data & 32'h3123_4ED1);
    chk[4] = ^(data & 32'hC2C1_323B);
    chk[5] = ^(data & 32'h2DCC_624C);
    chk[6] = ^(data & 32'h9850_5586);
    return chk ^ 7'h2A;
  endfunction

endpackage

// File: rtl/ibex_obi_resp_pipe.sv
// Fixed-latency, in-order response delay line; entries carry zero payload when not valid.
module ibex_obi_resp_pipe
  import ibex_obi_resp_pkg::*;
#(
  parameter int unsigned RespLatency = 1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  valid_i,
  input  resp_t resp_i,
  output logic  valid_o,
  output resp_t resp_o
);

  localparam int Lat = int'(RespLatency);

  logic  [Lat-1:0] valid_q;
  resp_t [Lat-1:0] resp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      resp_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      resp_q[0]  <= valid_i ? resp_i : '0;
      for (int i = 1; i < Lat; i++) begin
        valid_q[i] <= valid_q[i-1];
        resp_q[i]  <= resp_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Lat-1];
  assign resp_o  = resp_q[Lat-1];

endmodule

// File: rtl/ibex_obi_responder.sv
// OBI memory responder with fixed response latency and bounded outstanding requests.
// Define IBEX_OBI_RESP_INTG_EN to generate read integrity and check write integrity.
module ibex_obi_responder
  import ibex_obi_resp_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [6:0]  wdata_intg_i,
  input  logic        stall_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [6:0]  rdata_intg_o,
  output logic        err_o
);

  localparam int unsigned IdxW      = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam logic [31:0] SpanBytes = 32'(MemWords * 4);

  logic [31:0]     mem_q [MemWords];
  logic [2:0]      outstanding_q, outstanding_d, live_cnt;
  logic [31:0]     offset;
  logic [IdxW-1:0] idx;
  err_cause_e      cause;
  logic            err, gnt, wr_en, pipe_valid;
  resp_t           req_resp, pipe_resp;

  assign offset = addr_i - BaseAddr;
  assign idx    = offset[IdxW+1:2];

  always_comb begin
    cause = ErrNone;
    if (addr_i < BaseAddr || offset >= SpanBytes) begin
      cause = ErrRange;
    end else if (addr_i[1:0] != 2'b00) begin
      cause = ErrAlign;
`ifdef IBEX_OBI_RESP_INTG_EN
    end else if (we_i && (wdata_intg_i != secded_inv_39_32_intg(wdata_i))) begin
      cause = ErrIntg;
`endif
    end
  end

  assign err = (cause != ErrNone);

  // A response retiring this cycle frees its slot, so full-rate issue holds when
  // MaxOutstanding >= RespLatency.
  assign live_cnt = outstanding_q - {2'b00, pipe_valid};
  assign gnt      = req_i & ~stall_i & ~rst_i & (live_cnt < 3'(MaxOutstanding));
  assign wr_en    = gnt & we_i & ~err;

  always_comb begin
    req_resp     = '0;
    req_resp.err = err;
    if (!err && !we_i) begin
      req_resp.rdata = mem_q[idx];
    end
`ifdef IBEX_OBI_RESP_INTG_EN
    req_resp.intg = secded_inv_39_32_intg(req_resp.rdata);
`endif
  end

`ifndef IBEX_OBI_RESP_INTG_EN
  logic unused_wdata_intg;
  assign unused_wdata_intg = ^wdata_intg_i;
`endif

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (gnt && !pipe_valid) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (!gnt && pipe_valid) begin
      outstanding_d = outstanding_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  ibex_obi_resp_pipe #(
    .RespLatency(RespLatency)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(gnt),
    .resp_i (req_resp),
    .valid_o(pipe_valid),
    .resp_o (pipe_resp)
  );

  assign gnt_o        = gnt;
  assign rvalid_o     = pipe_valid;
  assign rdata_o      = pipe_resp.rdata;
  assign err_o        = pipe_resp.err;
  assign rdata_intg_o = pipe_resp.intg;

endmodule

// File: tb/tb_ibex_obi_responder.sv
// Directed bench: dut_a uses default parameters, dut_b uses RespLatency=3, MaxOutstanding=2.
module tb_ibex_obi_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req, a_we, a_stall, a_gnt, a_rvalid, a_err;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [6:0]  a_wintg, a_rintg;
  logic        b_req, b_we, b_stall, b_gnt, b_rvalid, b_err;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [6:0]  b_wintg, b_rintg;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  ibex_obi_responder dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt), .we_i(a_we), .be_i(a_be),
    .addr_i(a_addr), .wdata_i(a_wdata), .wdata_intg_i(a_wintg), .stall_i(a_stall),
    .rvalid_o(a_rvalid), .rdata_o(a_rdata), .rdata_intg_o(a_rintg), .err_o(a_err)
  );

  ibex_obi_responder #(
    .RespLatency(3),
    .MaxOutstanding(2)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt), .we_i(b_we), .be_i(b_be),
    .addr_i(b_addr), .wdata_i(b_wdata), .wdata_intg_i(b_wintg), .stall_i(b_stall),
    .rvalid_o(b_rvalid), .rdata_o(b_rdata), .rdata_intg_o(b_rintg), .err_o(b_err)
  );

  function automatic logic [6:0] tb_enc(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  c;
    m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
          32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    for (int k = 0; k < 7; k++) c[k] = ^(d & m[k]);
    return c ^ 7'h2A;
  endfunction

  function automatic logic [6:0] exp_intg(input logic [31:0] d);
`ifdef IBEX_OBI_RESP_INTG_EN
    return tb_enc(d);
`else
    return (d == 32'h0) ? 7'h0 : 7'h0;
`endif
  endfunction

  // One request on dut_a; waits (bounded) for its response.
  task automatic a_xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [6:0] wintg, output logic gnt,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic [6:0] intg);
    @(posedge clk); #1;
    a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata; a_wintg = wintg;
    @(negedge clk);
    gnt = a_gnt;
    @(posedge clk); #1;
    a_req = 1'b0; a_we = 1'b0;
    lat = 0; rdata = 'x; err = 1'bx; intg = 'x;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      if (a_rvalid === 1'b1) begin
        lat = i; rdata = a_rdata; err = a_err; intg = a_rintg;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a_req = 1'b1; b_req = 1'b1;
    a_addr = 32'h0010_0000; b_addr = 32'h0010_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt: gnt_a=%b gnt_b=%b, want 0 0", a_gnt, b_gnt);
    end
    n_tests++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0 || a_rintg !== 7'h0 ||
        b_rvalid !== 1'b0 || b_rdata !== 32'h0 || b_err !== 1'b0 || b_rintg !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: a=%b/%h/%b/%h b=%b/%h/%b/%h, want all 0",
               a_rvalid, a_rdata, a_err, a_rintg, b_rvalid, b_rdata, b_err, b_rintg);
    end
    @(posedge clk); #1;
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic test_write_read();
    logic g, e; int lat; logic [31:0] rd; logic [6:0] ig;
    a_xfer(1'b1, 4'hF, 32'h0010_0000, 32'hDEADBEEF, tb_enc(32'hDEADBEEF), g, lat, rd, e, ig);
    n_tests++;
    if (g !== 1'b1 || lat != 1 || e !== 1'b0 || rd !== 32'h0 || ig !== exp_intg(32'h0)) begin
      n_fail++;
      $display("FAIL write_full: gnt=%b lat=%0d err=%b rdata=%h intg=%h, want 1 1 0 0 %h",
               g, lat, e, rd, ig, exp_intg(32'h0));
    end
    a_xfer(1'b0, 4'hF, 32'h0010_0000, 32'h0, 7'h0, g, lat, rd, e, ig);
    n_tests++;
    if (g !== 1'b1 || lat != 1 || e !== 1'b0 || rd !== 32'hDEADBEEF ||
        ig !== exp_intg(32'hDEADBEEF)) begin
      n_fail++;
      $display("FAIL read_full: gnt=%b lat=%0d err=%b rdata=%h intg=%h, want 1 1 0 deadbeef %h",
               g, lat, e, rd, ig, exp_intg(32'hDEADBEEF));
    end
  endtask

  task automatic test_byte_write();
    logic g, e; int lat; logic [31:0] rd; logic [6:0] ig;
    a_xfer(1'b1, 4'b0001, 32'h0010_0000, 32'h0000_00AA, tb_enc(32'hAA), g, lat, rd, e, ig);
    a_xfer(1'b0, 4'hF, 32'h0010_0000, 32'h0, 7'h0, g, lat, rd, e, ig);
    n_tests++;
    if (lat != 1 || e !== 1'b0 || rd !== 32'hDEAD_BEAA) begin
      n_fail++;
      $display("FAIL byte0_merge: lat=%0d err=%b rdata=%h, want 1 0 deadbeaa", lat, e, rd);
    end
    a_xfer(1'b1, 4'b0000, 32'h0010_0000, 32'hFFFF_FFFF, tb_enc(32'hFFFF_FFFF), g, lat, rd, e, ig);
    n_tests++;
    if (g !== 1'b1 || lat != 1 || e !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL be_zero_resp: gnt=%b lat=%0d err=%b rdata=%h, want 1 1 0 0", g, lat, e, rd);
    end
    a_xfer(1'b1, 4'b0100, 32'h0010_0000, 32'h0055_0000, tb_enc(32'h0055_0000), g, lat, rd, e, ig);
    a_xfer(1'b0, 4'hF, 32'h0010_0000, 32'h0, 7'h0, g, lat, rd, e, ig);
    n_tests++;
    if (lat != 1 || e !== 1'b0 || rd !== 32'hDE55_BEAA) begin
      n_fail++;
      $display("FAIL byte2_merge: lat=%0d err=%b rdata=%h, want 1 0 de55beaa", lat, e, rd);
    end
  endtask

  task automatic test_errors();
    logic g, e; int lat; logic [31:0] rd; logic [6:0] ig;
    a_xfer(1'b0, 4'hF, 32'h0010_1000, 32'h0, 7'h0, g, lat, rd, e, ig);
    n_tests++;
    if (g !== 1'b1 || lat != 1 || e !== 1'b1 || rd !== 32'h0 || ig !== exp_intg(32'h0)) begin
      n_fail++;
      $display("FAIL err_above: gnt=%b lat=%0d err=%b rdata=%h intg=%h, want 1 1 1 0 %h",
               g, lat, e, rd, ig, exp_intg(32'h0));
    end
    a_xfer(1'b0, 4'hF, 32'h0010_0002, 32'h0, 7'h0, g, lat, rd, e, ig);
    n_tests++;
    if (lat != 1 || e !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_misalign: lat=%0d err=%b rdata=%h, want 1 1 0", lat, e, rd);
    end
    a_xfer(1'b1, 4'hF, 32'h0010_0001, 32'h1234_5678, tb_enc(32'h1234_5678), g, lat, rd, e, ig);
    n_tests++;
    if (lat != 1 || e !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_misalign_wr: lat=%0d err=%b rdata=%h, want 1 1 0", lat, e, rd);
    end
    a_xfer(1'b1, 4'hF, 32'h000F_FFFC, 32'h1234_5678, tb_enc(32'h1234_5678), g, lat, rd, e, ig);
    n_tests++;
    if (lat != 1 || e !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_below: lat=%0d err=%b rdata=%h, want 1 1 0", lat, e, rd);
    end
    a_xfer(1'b0, 4'hF, 32'h0010_0000, 32'h0, 7'h0, g, lat, rd, e, ig);
    n_tests++;
    if (e !== 1'b0 || rd !== 32'hDE55_BEAA) begin
      n_fail++;
      $display("FAIL err_no_write: err=%b rdata=%h, want 0 de55beaa", e, rd);
    end
    a_xfer(1'b1, 4'hF, 32'h0010_0FFC, 32'hCAFE_F00D, tb_enc(32'hCAFE_F00D), g, lat, rd, e, ig);
    a_xfer(1'b0, 4'hF, 32'h0010_0FFC, 32'h0, 7'h0, g, lat, rd, e, ig);
    n_tests++;
    if (lat != 1 || e !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL last_word: lat=%0d err=%b rdata=%h, want 1 0 cafef00d", lat, e, rd);
    end
  endtask

  task automatic test_intg();
    logic g, e; int lat; logic [31:0] rd; logic [6:0] ig;
`ifdef IBEX_OBI_RESP_INTG_EN
    a_xfer(1'b1, 4'hF, 32'h0010_0004, 32'h1111_1111, tb_enc(32'h1111_1111), g, lat, rd, e, ig);
    n_tests++;
    if (lat != 1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL intg_good_wr: lat=%0d err=%b, want 1 0", lat, e);
    end
    a_xfer(1'b1, 4'hF, 32'h0010_0004, 32'h2222_2222, tb_enc(32'h2222_2222) ^ 7'h01,
           g, lat, rd, e, ig);
    n_tests++;
    if (lat != 1 || e !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL intg_bad_wr: lat=%0d err=%b rdata=%h, want 1 1 0", lat, e, rd);
    end
    a_xfer(1'b0, 4'hF, 32'h0010_0004, 32'h0, 7'h0, g, lat, rd, e, ig);
    n_tests++;
    if (e !== 1'b0 || rd !== 32'h1111_1111 || ig !== tb_enc(32'h1111_1111)) begin
      n_fail++;
      $display("FAIL intg_read: err=%b rdata=%h intg=%h, want 0 11111111 %h",
               e, rd, ig, tb_enc(32'h1111_1111));
    end
`else
    a_xfer(1'b1, 4'hF, 32'h0010_0004, 32'h3333_3333, 7'h55, g, lat, rd, e, ig);
    n_tests++;
    if (lat != 1 || e !== 1'b0 || ig !== 7'h0) begin
      n_fail++;
      $display("FAIL intg_ignored_wr: lat=%0d err=%b intg=%h, want 1 0 0", lat, e, ig);
    end
    a_xfer(1'b0, 4'hF, 32'h0010_0004, 32'h0, 7'h0, g, lat, rd, e, ig);
    n_tests++;
    if (e !== 1'b0 || rd !== 32'h3333_3333 || ig !== 7'h0) begin
      n_fail++;
      $display("FAIL intg_off_read: err=%b rdata=%h intg=%h, want 0 33333333 0", e, rd, ig);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp [4];
    addrs = '{32'h0010_0000, 32'h0010_0FFC, 32'h0010_0000, 32'h0010_0FFC};
    exp   = '{32'hDE55_BEAA, 32'hCAFE_F00D, 32'hDE55_BEAA, 32'hCAFE_F00D};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        a_req = 1'b1; a_we = 1'b0; a_be = 4'hF; a_addr = addrs[i];
      end else begin
        a_req = 1'b0;
      end
      @(negedge clk);
      if (i < 4) begin
        n_tests++;
        if (a_gnt !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_gnt%0d: gnt=%b, want 1", i, a_gnt);
        end
      end
      if (i > 0) begin
        n_tests++;
        if (a_rvalid !== 1'b1 || a_err !== 1'b0 || a_rdata !== exp[i-1]) begin
          n_fail++;
          $display("FAIL b2b_resp%0d: rvalid=%b err=%b rdata=%h, want 1 0 %h",
                   i - 1, a_rvalid, a_err, a_rdata, exp[i-1]);
        end
      end
    end
    @(posedge clk); #1;
    a_req = 1'b1; a_stall = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_gnt !== 1'b0 || a_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall: gnt=%b rvalid=%b, want 0 0", a_gnt, a_rvalid);
    end
    @(posedge clk); #1;
    a_req = 1'b0; a_stall = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_resp: rvalid=%b, want 0", a_rvalid);
    end
  endtask

  task automatic test_pipelined();
    vec_t     v [6];
    int       gcyc [6];
    int       gi = 0;
    int       ri = 0;
    bit [5:0] exp_g = 6'b011011;
    v[0] = '{1'b1, 32'h0010_0000, 32'h0A0A_0A0A, 32'h0,         1'b0};
    v[1] = '{1'b0, 32'h0010_0000, 32'h0,         32'h0A0A_0A0A, 1'b0};
    v[2] = '{1'b0, 32'h0010_0002, 32'h0,         32'h0,         1'b1};
    v[3] = '{1'b1, 32'h0010_0008, 32'h0000_0005, 32'h0,         1'b0};
    v[4] = '{1'b0, 32'h0010_0008, 32'h0,         32'h0000_0005, 1'b0};
    v[5] = '{1'b0, 32'h0020_0000, 32'h0,         32'h0,         1'b1};
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (gi < 6) begin
        b_req = 1'b1; b_we = v[gi].we; b_be = 4'hF; b_addr = v[gi].addr;
        b_wdata = v[gi].wdata; b_wintg = tb_enc(v[gi].wdata);
      end else begin
        b_req = 1'b0; b_we = 1'b0;
      end
      @(negedge clk);
      if (c < 6) begin
        n_tests++;
        if (b_gnt !== exp_g[c]) begin
          n_fail++;
          $display("FAIL pipe_gnt_c%0d: gnt=%b, want %b", c, b_gnt, exp_g[c]);
        end
      end
      if (b_gnt === 1'b1 && gi < 6) begin
        gcyc[gi] = c;
        gi++;
      end
      if (b_rvalid === 1'b1) begin
        n_tests++;
        if (ri >= 6) begin
          n_fail++;
          $display("FAIL pipe_extra_resp: rvalid=1 at cycle %0d, want 0", c);
        end else if (c - gcyc[ri] != 3 || b_err !== v[ri].err || b_rdata !== v[ri].rdata) begin
          n_fail++;
          $display("FAIL pipe_resp%0d: lat=%0d err=%b rdata=%h, want 3 %b %h",
                   ri, c - gcyc[ri], b_err, b_rdata, v[ri].err, v[ri].rdata);
        end
        ri++;
      end
    end
    n_tests++;
    if (ri != 6) begin
      n_fail++;
      $display("FAIL pipe_resp_count: got %0d responses, want 6", ri);
    end
  endtask

  task automatic test_reset_inflight();
    logic g0, g1;
    bit   seen = 1'b0;
    bit [2:0] exp_g = 3'b011;
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_be = 4'hF; b_addr = 32'h0010_0000;
    @(negedge clk); g0 = b_gnt;
    @(negedge clk); g1 = b_gnt;
    n_tests++;
    if (g0 !== 1'b1 || g1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_grants: gnt=%b,%b, want 1,1", g0, g1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_gnt: gnt=%b, want 0", b_gnt);
    end
    @(posedge clk); #1;
    rst = 1'b0; b_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_rvalid !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_discard: rvalid seen=1 after reset, want 0");
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      b_req = 1'b1;
      @(negedge clk);
      n_tests++;
      if (b_gnt !== exp_g[c]) begin
        n_fail++;
        $display("FAIL rst_regrant_c%0d: gnt=%b, want %b", c, b_gnt, exp_g[c]);
      end
    end
    @(posedge clk); #1;
    b_req = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = '0; a_wdata = '0; a_wintg = '0;
    a_stall = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = '0; b_wdata = '0; b_wintg = '0;
    b_stall = 1'b0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_errors();
    test_intg();
    test_back_to_back();
    test_pipelined();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
